nios2_p3_led: RTL and testbench
===============================

NIOS2_P3_LED -- requirements
Module: nios2_p3_led

Interface
REQ-001 Parameter: DATA_WIDTH, 7, width of out_port and of the DATA/BLINK_EN registers.
REQ-002 Parameter: CNT_WIDTH, 16, width of the PERIOD register and the blink counter.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-005 Port: address  input  3  Avalon-MM word address.
REQ-006 Port: chipselect  input  1  slave select.
REQ-007 Port: write_n  input  1  active-low write strobe.
REQ-008 Port: writedata  input  32  write data.
REQ-009 Port: readdata  output  32  registered read data.
REQ-010 Port: out_port  output  DATA_WIDTH  LED/pin drive.

Function
REQ-011 Write SHALL occur in a cycle with chipselect=1 and write_n=0; the register is updated at that clock edge.
REQ-012 Register map SHALL be:
- 0 DATA: R/W, [DATA_WIDTH-1:0].
- 1 BLINK_EN: R/W, per-bit blink select.
- 2 PERIOD: R/W, [CNT_WIDTH-1:0], half-period minus one in clk cycles.
- 3 STATUS: RO, bit0 = phase.
- 4 OUTSET: WO; DATA <= DATA | writedata.
- 5 OUTCLEAR: WO; DATA <= DATA & ~writedata.
- 6, 7: reserved; write ignored.
REQ-013 Writedata bits above the register width SHALL be ignored; unused readdata bits SHALL read 0.
REQ-014 readdata SHALL be registered every clock from the mux of address, independent of chipselect: read latency is exactly 1 cycle.
REQ-015 Reads of OUTSET, OUTCLEAR and reserved addresses SHALL return 0.
REQ-016 Reads SHALL have no side effects.
REQ-017 out_port SHALL equal DATA & ~(BLINK_EN & {DATA_WIDTH{~phase}}), decoded combinationally from registers, so a write is visible on out_port in the cycle after its edge.
REQ-018 Blink timer, PERIOD != 0:
- counter increments each cycle.
- When counter == PERIOD: counter <= 0 and phase toggles.
- phase therefore toggles every PERIOD+1 cycles.
REQ-019 PERIOD == 0 SHALL hold counter at 0 and phase at 1, so blinking bits show DATA steadily.
REQ-020 Any write to PERIOD SHALL clear counter to 0 and set phase to 1 at that edge, overriding a same-cycle terminal-count toggle.
REQ-021 Writes to DATA, BLINK_EN, OUTSET and OUTCLEAR SHALL NOT disturb counter or phase.
REQ-022 Counter SHALL never exceed PERIOD.
REQ-023 Writing PERIOD below the current counter value is covered by REQ-020; no wrap through 2^CNT_WIDTH SHALL occur.

Reset
REQ-024 With reset_n=0 at a clock edge, the block SHALL load: DATA=0, BLINK_EN=0, PERIOD=0, counter=0, phase=1, readdata=0; out_port therefore reads 0.
REQ-025 Reset SHALL take priority over a same-cycle write.
REQ-026 Reset mid-blink SHALL fully restart the timer; no state survives reset.

Structure
REQ-027 Shared package nios2_p3_led_pkg SHALL hold the address constants (ADDR_DATA .. ADDR_OUTCLEAR) and register reset values.
REQ-028 Blink counter and phase SHALL live in sub-module nios2_p3_led_blink_tmr, with inputs period and restart and output phase.
REQ-029 The register file and read mux SHALL be in the top module.

Verification
REQ-030 Reset, then read addresses 0-7 -> readdata = 0 everywhere except STATUS = 0x1; out_port = 0.
REQ-031 Write DATA=0x55, then OUTSET 0x0A, then OUTCLEAR 0x41 -> out_port 0x55, 0x5F, 0x1E on the cycles after each write; reading DATA returns 0x1E one cycle after address is applied.
REQ-032 Write DATA=0x7F, BLINK_EN=0x03, PERIOD=4 -> out_port alternates 0x7F/0x7C every 5 cycles; STATUS bit0 tracks the alternation.
REQ-033 Rewrite PERIOD=9 on a counter==PERIOD cycle -> no toggle; phase=1 and the next toggle comes exactly 10 cycles later.
REQ-034 Assert reset_n=0 for one cycle during blinking with a same-cycle write to DATA=0x12 -> all registers are 0, phase=1, and DATA stays 0.
REQ-035 Write 0xFFFFFFFF to address 6, then to PERIOD with PERIOD=0 -> no register changes on the first write; PERIOD reads 0xFFFF with the upper 16 bits reading 0.

Source files
------------

// File: rtl/nios2_p3_led_pkg.sv
// Shared constants for the nios2_p3_led Avalon-MM LED/blink peripheral:
// register word addresses and reset values.
package nios2_p3_led_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam logic [31:0] RST_DATA     = 32'h0000_0000;
  localparam logic [31:0] RST_BLINK_EN = 32'h0000_0000;
  localparam logic [31:0] RST_PERIOD   = 32'h0000_0000;
  localparam logic [31:0] RST_READDATA = 32'h0000_0000;
  localparam logic        RST_PHASE    = 1'b1;

endpackage

// File: rtl/nios2_p3_led_blink_tmr.sv
// Blink timer: up-counter with terminal-count compare against PERIOD that
// toggles the blink phase every PERIOD+1 cycles.
//
// phase | meaning
//   1   | blinking bits show DATA (also idle / restart / PERIOD==0)
//   0   | blinking bits forced low
module nios2_p3_led_blink_tmr
  import nios2_p3_led_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic                 restart,
  output logic                 phase
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_phase;

  // restart wins over a same-cycle terminal count; >= keeps the counter from
  // ever running past PERIOD, so there is no wrap through 2^CNT_WIDTH
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= RST_PHASE;
    end else if (restart || (period == '0)) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt >= period) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/nios2_p3_led.sv
// Avalon-MM LED peripheral: DATA/BLINK_EN/PERIOD register file, set/clear
// aliases, registered read mux and blink-masked pin drive.
module nios2_p3_led
  import nios2_p3_led_pkg::*;
#(
  parameter int DATA_WIDTH = 7,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_blink_en;
  logic [CNT_WIDTH-1:0]  r_period;
  logic [31:0]           r_readdata;

  logic                  w_wr;
  logic                  w_period_wr;
  logic                  w_phase;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [31:0]           w_rdata;
  logic                  w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_period_wr    = w_wr && (address == ADDR_PERIOD);
  assign w_wdata        = writedata[DATA_WIDTH-1:0];
  assign w_unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data     <= RST_DATA[DATA_WIDTH-1:0];
      r_blink_en <= RST_BLINK_EN[DATA_WIDTH-1:0];
      r_period   <= RST_PERIOD[CNT_WIDTH-1:0];
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:     r_data     <= w_wdata;
        ADDR_BLINK_EN: r_blink_en <= w_wdata;
        ADDR_PERIOD:   r_period   <= writedata[CNT_WIDTH-1:0];
        ADDR_OUTSET:   r_data     <= r_data | w_wdata;
        ADDR_OUTCLEAR: r_data     <= r_data & ~w_wdata;
        default:       ;
      endcase
    end
  end

  nios2_p3_led_blink_tmr #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_blink_tmr (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (r_period),
    .restart (w_period_wr),
    .phase   (w_phase)
  );

  // read mux ignores chipselect so readdata always lags address by one cycle
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA:     w_rdata[DATA_WIDTH-1:0] = r_data;
      ADDR_BLINK_EN: w_rdata[DATA_WIDTH-1:0] = r_blink_en;
      ADDR_PERIOD:   w_rdata[CNT_WIDTH-1:0]  = r_period;
      ADDR_STATUS:   w_rdata[0]              = w_phase;
      default:       w_rdata                 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_readdata <= RST_READDATA;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_data & ~(r_blink_en & {DATA_WIDTH{~w_phase}});

endmodule

// File: tb/tb_nios2_p3_led.sv
// Directed scoreboard bench for nios2_p3_led: expectations are queued as
// stimulus is applied and popped when the DUT output is sampled.
module tb_nios2_p3_led;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [6:0]  out_port;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  int          mcnt;
  logic        mph;
  logic [31:0] rv;

  nios2_p3_led #(
    .DATA_WIDTH (7),
    .CNT_WIDTH  (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // all tasks start and end just after a falling edge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    if (a == 3'd2) begin
      mcnt = 0;
      mph  = 1'b1;
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address = a;
    @(negedge clk);
    v = readdata;
  endtask

  // one clock of blinking with address parked on STATUS
  task automatic step(input int per, input logic [6:0] data, input logic [6:0] blink);
    logic prev;
    @(negedge clk);
    prev = mph;
    if (mcnt == per) begin
      mcnt = 0;
      mph  = ~mph;
    end else begin
      mcnt++;
    end
    exp_q.push_back({25'd0, (mph ? data : (data & ~blink))});
    chk("blink_out", {25'd0, out_port});
    exp_q.push_back({31'd0, prev});
    chk("blink_status", readdata);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    mcnt       = 0;
    mph        = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    exp_q.push_back(32'd0);
    chk("rst_out", {25'd0, out_port});
    exp_q.push_back(32'd0);
    chk("rst_readdata", readdata);
    for (int a = 0; a < 8; a++) begin
      exp_q.push_back((a == 3) ? 32'd1 : 32'd0);
      rd(a[2:0], rv);
      chk($sformatf("rst_read_a%0d", a), rv);
    end

    exp_q.push_back(32'h55);
    wr(3'd0, 32'h55);
    chk("data_write", {25'd0, out_port});
    exp_q.push_back(32'h5F);
    wr(3'd4, 32'h0A);
    chk("outset", {25'd0, out_port});
    exp_q.push_back(32'h1E);
    wr(3'd5, 32'h41);
    chk("outclear", {25'd0, out_port});
    exp_q.push_back(32'h1E);
    rd(3'd0, rv);
    chk("read_data", rv);
    exp_q.push_back(32'h0);
    rd(3'd4, rv);
    chk("read_outset", rv);

    wr(3'd0, 32'h7F);
    exp_q.push_back(32'h7F);
    wr(3'd1, 32'h03);
    chk("blink_en_p0", {25'd0, out_port});
    exp_q.push_back(32'h7F);
    wr(3'd2, 32'd4);
    chk("period_wr_out", {25'd0, out_port});
    address = 3'd3;
    for (int i = 0; i < 25; i++) step(4, 7'h7F, 7'h03);

    for (int k = 0; k < 6 && mcnt != 4; k++) step(4, 7'h7F, 7'h03);
    exp_q.push_back(32'h7F);
    wr(3'd2, 32'd9);
    chk("period_rewrite_tc", {25'd0, out_port});
    address = 3'd3;
    for (int i = 0; i < 24; i++) step(9, 7'h7F, 7'h03);
    exp_q.push_back(32'd9);
    rd(3'd2, rv);
    chk("read_period", rv);
    mcnt++;
    address = 3'd3;

    for (int k = 0; k < 12 && mph != 1'b0; k++) step(9, 7'h7F, 7'h03);
    reset_n    = 1'b0;
    address    = 3'd0;
    writedata  = 32'h12;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    mcnt       = 0;
    mph        = 1'b1;
    exp_q.push_back(32'd0);
    chk("midreset_out", {25'd0, out_port});
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back((a == 3) ? 32'd1 : 32'd0);
      rd(a[2:0], rv);
      chk($sformatf("midreset_read_a%0d", a), rv);
    end

    wr(3'd6, 32'hFFFF_FFFF);
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back((a == 3) ? 32'd1 : 32'd0);
      rd(a[2:0], rv);
      chk($sformatf("reserved_wr_a%0d", a), rv);
    end
    exp_q.push_back(32'd0);
    rd(3'd6, rv);
    chk("read_reserved", rv);
    wr(3'd2, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_FFFF);
    rd(3'd2, rv);
    chk("period_width", rv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
